spi_byte_master: RTL and testbench



---
 rtl/spi_byte_master.sv | 186 ++++++++++++++++++
 tb/tb_spi_byte_master.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_master.sv
// ---------------------------------------------------------------------------
// spi_byte_master
// Byte-wide SPI mode-0 master shift engine. The upstream sequencer owns chip
// select; this block shifts exactly one byte (MSB first) per request strobe
// and reports completion through a wait_n busy/ready handshake.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active high
//   enviar_dato  one-cycle strobe: transmit din
//   recibir_dato one-cycle strobe: transmit 8'hFF and capture incoming byte
//   din[7:0]     byte to transmit, sampled on the accepting edge
//   dout[7:0]    last captured byte, held until the next transfer completes
//   wait_n       1 = idle/ready, 0 = transfer in progress
//   spi_clk      SPI clock, idles low
//   spi_di       MOSI towards the flash DI pin
//   spi_do       MISO from the flash DO pin
//
// Parameter CLKDIV (1..255) is the spi_clk half-period in clk cycles.
// ---------------------------------------------------------------------------
module spi_byte_master #(
  parameter int CLKDIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enviar_dato,
  input  logic       recibir_dato,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       wait_n,
  output logic       spi_clk,
  output logic       spi_di,
  input  logic       spi_do
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_e;

  // Terminal count of the half-period divider.
  localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] dout_q, dout_d;
  logic       wait_n_q, wait_n_d;
  logic       spi_clk_q, spi_clk_d;
  logic       spi_di_q, spi_di_d;

  logic       start_s;
  logic       phase_end_s;
  logic       last_bit_s;
  logic [7:0] load_byte_s;

  assign start_s     = enviar_dato | recibir_dato;
  assign phase_end_s = (div_q == DIV_LAST);
  assign last_bit_s  = (bit_q == 3'd7);
  // Send wins when both strobes arrive together; a pure receive clocks out ones.
  assign load_byte_s = enviar_dato ? din : 8'hFF;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_q     <= 8'd0;
      bit_q     <= 3'd0;
      tx_q      <= 8'hFF;
      rx_q      <= 8'hFF;
      dout_q    <= 8'hFF;
      wait_n_q  <= 1'b1;
      spi_clk_q <= 1'b0;
      spi_di_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      dout_q    <= dout_d;
      wait_n_q  <= wait_n_d;
      spi_clk_q <= spi_clk_d;
      spi_di_q  <= spi_di_d;
    end
  end

  // Next-state logic: IDLE -> LOW/HIGH alternating for 8 bits -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_LOW;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (phase_end_s) begin
          state_d = ST_HIGH;
        end else begin
          state_d = ST_LOW;
        end
      end
      ST_HIGH: begin
        if (phase_end_s) begin
          state_d = last_bit_s ? ST_IDLE : ST_LOW;
        end else begin
          state_d = ST_HIGH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    div_d     = div_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    dout_d    = dout_q;
    wait_n_d  = wait_n_q;
    spi_clk_d = spi_clk_q;
    spi_di_d  = spi_di_q;
    case (state_q)
      ST_IDLE: begin
        // Strobes are only honoured here, so requests during a transfer
        // (including on the completion edge) are dropped, not queued.
        if (start_s) begin
          tx_d     = load_byte_s;
          spi_di_d = load_byte_s[7];
          bit_d    = 3'd0;
          div_d    = 8'd0;
          wait_n_d = 1'b0;
        end else begin
          div_d = div_q;
        end
      end
      ST_LOW: begin
        if (phase_end_s) begin
          div_d     = 8'd0;
          spi_clk_d = 1'b1;
          // MISO is sampled on the same edge that raises spi_clk.
          rx_d      = {rx_q[6:0], spi_do};
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_HIGH: begin
        if (phase_end_s) begin
          div_d     = 8'd0;
          spi_clk_d = 1'b0;
          if (last_bit_s) begin
            dout_d   = rx_q;
            wait_n_d = 1'b1;
            spi_di_d = 1'b1;
          end else begin
            // MOSI only moves on the falling edge, giving a full low phase
            // of setup before the next rising edge.
            tx_d     = {tx_q[6:0], 1'b1};
            spi_di_d = tx_q[6];
            bit_d    = bit_q + 3'd1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: begin
        div_d = 8'd0;
      end
    endcase
  end

  assign dout    = dout_q;
  assign wait_n  = wait_n_q;
  assign spi_clk = spi_clk_q;
  assign spi_di  = spi_di_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// ---------------------------------------------------------------------------
// tb_spi_byte_master
// Two instances (CLKDIV=1 and CLKDIV=3) driven by a table of directed
// transfers, a few hand-written corner sequences and randomized transfers.
// A behavioural slave shifts its byte out on spi_clk falling edges; the
// expected MOSI byte, captured byte and timing come from the transfer rules.
// ---------------------------------------------------------------------------
module tb_spi_byte_master;

  logic       clk;
  logic       rst  [2];
  logic       env  [2];
  logic       rec  [2];
  logic [7:0] din  [2];
  logic [7:0] dout [2];
  logic       wn   [2];
  logic       sclk [2];
  logic       sdi  [2];
  logic       sdo  [2];

  int errors;
  int checks;

  spi_byte_master #(.CLKDIV(1)) u_dut1 (
    .clk(clk), .rst(rst[0]), .enviar_dato(env[0]), .recibir_dato(rec[0]),
    .din(din[0]), .dout(dout[0]), .wait_n(wn[0]), .spi_clk(sclk[0]),
    .spi_di(sdi[0]), .spi_do(sdo[0])
  );

  spi_byte_master #(.CLKDIV(3)) u_dut3 (
    .clk(clk), .rst(rst[1]), .enviar_dato(env[1]), .recibir_dato(rec[1]),
    .din(din[1]), .dout(dout[1]), .wait_n(wn[1]), .spi_clk(sclk[1]),
    .spi_di(sdi[1]), .spi_do(sdo[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         u;
    bit         snd;
    bit         rcv;
    logic [7:0] d;
    logic [7:0] slv;
    int         extra;
    logic [7:0] exp_mosi;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[8];

  function automatic int div_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete transfer on instance u, observed at every falling clk edge.
  // extra > 0 pulses enviar_dato again after that many busy cycles.
  task automatic xfer(input int u, input bit do_send, input bit do_recv,
                      input logic [7:0] d, input logic [7:0] slave,
                      input int extra, input logic [7:0] exp_mosi,
                      input logic [7:0] exp_dout, input string tag);
    logic [7:0] sb;
    logic [7:0] mosi;
    logic       prev_clk;
    int         rises;
    int         low_cnt;
    int         bad;
    int         run;
    bit         done;
    int         dv;
    dv       = div_of(u);
    sb       = slave;
    mosi     = 8'h00;
    rises    = 0;
    low_cnt  = 0;
    bad      = 0;
    run      = 0;
    done     = 1'b0;
    prev_clk = 1'b0;
    sdo[u]   = sb[7];
    @(negedge clk);
    env[u] = do_send;
    rec[u] = do_recv;
    din[u] = d;
    @(negedge clk);
    env[u] = 1'b0;
    rec[u] = 1'b0;
    din[u] = ~d;
    check({tag, " busy_after_strobe"}, int'(wn[u]), 0);
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      if (wn[u] == 1'b0) begin
        low_cnt++;
        if (sclk[u] != prev_clk) begin
          if (run != dv) bad++;
          run = 1;
          if (sclk[u]) begin
            rises++;
            mosi = {mosi[6:0], sdi[u]};
          end else begin
            sb     = {sb[6:0], 1'b0};
            sdo[u] = sb[7];
          end
        end else begin
          run++;
        end
        prev_clk = sclk[u];
        env[u] = (low_cnt == extra);
        din[u] = 8'h00;
        @(negedge clk);
      end else begin
        done = 1'b1;
        if (run != dv) bad++;
      end
    end
    env[u] = 1'b0;
    check({tag, " completed"}, int'(done), 1);
    check({tag, " busy_cycles"}, low_cnt, 16 * dv);
    check({tag, " rising_edges"}, rises, 8);
    check({tag, " phase_len_errs"}, bad, 0);
    check({tag, " mosi"}, int'(mosi), int'(exp_mosi));
    check({tag, " dout"}, int'(dout[u]), int'(exp_dout));
    check({tag, " end_sclk"}, int'(sclk[u]), 0);
    check({tag, " end_sdi"}, int'(sdi[u]), 1);
    @(negedge clk);
    check({tag, " still_idle"}, int'(wn[u]), 1);
    check({tag, " idle_sclk"}, int'(sclk[u]), 0);
    check({tag, " dout_held"}, int'(dout[u]), int'(exp_dout));
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] rs;
    int         ru;
    bit         rsnd;
    bit         rrcv;
    int         rises;
    logic       prev;

    errors = 0;
    checks = 0;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      env[i] = 1'b0;
      rec[i] = 1'b0;
      din[i] = 8'h00;
      sdo[i] = 1'b1;
    end

    vecs[0] = '{0, 1'b1, 1'b0, 8'h9F, 8'h00, 0,  8'h9F, 8'h00};
    vecs[1] = '{0, 1'b0, 1'b1, 8'h00, 8'hEF, 0,  8'hFF, 8'hEF};
    vecs[2] = '{1, 1'b1, 1'b0, 8'hA5, 8'h3A, 0,  8'hA5, 8'h3A};
    vecs[3] = '{0, 1'b1, 1'b0, 8'h9F, 8'h5A, 5,  8'h9F, 8'h5A};
    vecs[4] = '{0, 1'b0, 1'b1, 8'h00, 8'hEF, 0,  8'hFF, 8'hEF};
    vecs[5] = '{0, 1'b1, 1'b1, 8'h3C, 8'h55, 0,  8'h3C, 8'h55};
    vecs[6] = '{1, 1'b1, 1'b1, 8'h3C, 8'h55, 20, 8'h3C, 8'h55};
    vecs[7] = '{0, 1'b1, 1'b0, 8'h81, 8'h7E, 16, 8'h81, 8'h7E};

    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset%0d wait_n", i), int'(wn[i]), 1);
      check($sformatf("reset%0d sclk", i), int'(sclk[i]), 0);
      check($sformatf("reset%0d sdi", i), int'(sdi[i]), 1);
      check($sformatf("reset%0d dout", i), int'(dout[i]), 8'hFF);
    end

    for (int i = 0; i < 8; i++) begin
      xfer(vecs[i].u, vecs[i].snd, vecs[i].rcv, vecs[i].d, vecs[i].slv,
           vecs[i].extra, vecs[i].exp_mosi, vecs[i].exp_dout,
           $sformatf("vec%0d", i));
    end

    // Reset after the 4th rising spi_clk edge aborts the transfer.
    @(negedge clk);
    sdo[0] = 1'b0;
    env[0] = 1'b1;
    din[0] = 8'hC3;
    @(negedge clk);
    env[0] = 1'b0;
    rises  = 0;
    prev   = 1'b0;
    for (int cyc = 0; cyc < 100 && rises < 4; cyc++) begin
      if (sclk[0] && !prev) rises++;
      prev = sclk[0];
      if (rises < 4) @(negedge clk);
    end
    check("abort reached_4_edges", rises, 4);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("abort sclk", int'(sclk[0]), 0);
    check("abort sdi", int'(sdi[0]), 1);
    check("abort wait_n", int'(wn[0]), 1);
    check("abort dout", int'(dout[0]), 8'hFF);
    xfer(0, 1'b0, 1'b1, 8'h00, 8'h12, 0, 8'hFF, 8'h12, "after_abort");

    // Randomized transfers checked against the transfer rules.
    for (int i = 0; i < 12; i++) begin
      ru   = int'($urandom_range(1, 0));
      rd   = 8'($urandom);
      rs   = 8'($urandom);
      rsnd = 1'($urandom);
      rrcv = rsnd ? 1'($urandom) : 1'b1;
      xfer(ru, rsnd, rrcv, rd, rs, 0, rsnd ? rd : 8'hFF, rs,
           $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
